clock_set_controller: RTL and testbench
=======================================

CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, cycles a button is held before auto-repeat begins.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 10_000_000, auto-repeat pulse period in cycles.
REQ-003 SHALL have parameter BLINK_CYCLES, default 25_000_000, half-period of the field blink in cycles.
REQ-004 SHALL have parameter IDLE_CYCLES, default 1_000_000_000, button-idle cycles in a set state before auto-return to RUN.
REQ-005 SHALL have port clock, input, 1, 100 MHz system clock; the block uses one clock only.
REQ-006 SHALL have port reset, input, 1, reset that is synchronous and active-low.
REQ-007 SHALL have port pulse_1hz, input, 1, single-cycle seconds strobe, synchronous to clock.
REQ-008 SHALL have ports mode_button, add_button and sub_button, each input, 1, debounced, synchronized level, high = pressed.
REQ-009 SHALL have port tick_en, output, 1, single-cycle "advance time by one second" strobe to the time counter.
REQ-010 SHALL have port inc_pulse, output, 1, single-cycle "increment selected field" strobe.
REQ-011 SHALL have port dec_pulse, output, 1, single-cycle "decrement selected field" strobe.
REQ-012 SHALL have port field_sel, output, 2, selected field: 00 none, 01 hours, 10 minutes, 11 seconds.
REQ-013 SHALL have port blank, output, 1, high = display driver blanks the selected field's digits.
REQ-014 SHALL have port setting, output, 1, high in any set state.

Function
REQ-015 SHALL detect a press as a button sampled high at the current edge and low at the previous edge.
REQ-016 SHALL implement the FSM RUN -> SET_HOURS -> SET_MINUTES -> SET_SECONDS -> RUN, advancing one state per mode press.
REQ-017 SHALL drive field_sel and setting from the registered state: RUN = 00/0, SET_HOURS = 01/1, SET_MINUTES = 10/1, SET_SECONDS = 11/1.
REQ-018 SHALL assert tick_en for one cycle, in the cycle after pulse_1hz is sampled high, only if the state at that sample is RUN.
REQ-019 SHALL drop any pulse_1hz seen in a set state, with no queuing or catch-up after return to RUN.
REQ-020 SHALL ignore add_button and sub_button in RUN.
REQ-021 SHALL assert inc_pulse (add) or dec_pulse (sub) for exactly one cycle, one cycle after a press is detected in a set state.
REQ-022 SHALL count held cycles while a single add or sub stays high; after HOLD_CYCLES cycles from the press, SHALL emit one further pulse, then one pulse every REPEAT_CYCLES until release.
REQ-023 SHALL clear the hold/repeat counter on release.
REQ-024 SHALL treat add and sub high together as a chord: no pulses, repeat counter cleared, lockout set; lockout clears only when both are low, and the next pulse requires a fresh press.
REQ-025 SHALL give a mode press priority over add/sub in the same cycle: the state advances, no inc/dec pulse, repeat cleared, lockout set until add and sub are both low.
REQ-026 SHALL never assert inc_pulse and dec_pulse in the same cycle, nor either one together with tick_en.
REQ-027 SHALL run an idle counter in set states, cleared by any button high; on reaching IDLE_CYCLES it SHALL move to RUN with the idle counter cleared.
REQ-028 SHALL toggle blank every BLINK_CYCLES in set states; blink counter and blank SHALL clear on every state change.
REQ-029 SHALL hold blank at 0 while add or sub is high and in RUN.
REQ-030 SHALL size all counters to hold their parameter value; counters SHALL saturate or clear, never wrap.

Reset
REQ-031 SHALL, while reset is low at a clock edge, set state to RUN; tick_en, inc_pulse, dec_pulse, blank, setting and lockout to 0; field_sel to 00; all counters to 0.
REQ-032 SHALL load the previous-sample registers with 1 on reset, so a button held through reset release is not a press.
REQ-033 SHALL, on reset asserted mid-repeat or in any set state, return to RUN on that edge with no further pulses.

Verification (HOLD_CYCLES=8, REPEAT_CYCLES=4, BLINK_CYCLES=3, IDLE_CYCLES=50)
REQ-034 SHALL cover: pulse_1hz every 10 cycles in RUN -> tick_en one cycle after each; 3 mode presses -> field_sel 01,10,11, pulses dropped; 4th press -> 00, tick_en resumes on next pulse.
REQ-035 SHALL cover: SET_MINUTES, add held 20 cycles -> inc_pulse at press+1, then at press+9, +13, +17, +21; none after release.
REQ-036 SHALL cover: sub held, add raised 3 cycles later -> dec_pulse only at press+1; no pulses until both low; next sub press -> one dec_pulse.
REQ-037 SHALL cover: mode and add pressed in the same cycle in SET_HOURS -> field_sel 10, no inc_pulse; add held -> no pulses until released and re-pressed.
REQ-038 SHALL cover: SET_SECONDS with no buttons -> blank toggles every 3 cycles; after 50 idle cycles -> field_sel 00, blank 0, setting 0.
REQ-039 SHALL cover: add held through reset deassertion in RUN, then mode press -> no inc_pulse in SET_HOURS until add is released and re-pressed.

Source files
------------

// File: rtl/clock_set_controller.sv
// Clock-setting front end: mode/add/sub button handling, hold-to-repeat, field blink,
// idle timeout and gating of the 1 Hz tick while a field is being set.
module clock_set_controller #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned BLINK_CYCLES  = 25_000_000,
  parameter int unsigned IDLE_CYCLES   = 1_000_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pulse_1hz,
  input  logic       mode_button,
  input  logic       add_button,
  input  logic       sub_button,
  output logic       tick_en,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic [1:0] field_sel,
  output logic       blank,
  output logic       setting
);

  localparam int unsigned CntMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdleW  = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_CYCLES + 1);

  localparam logic [CntW-1:0]   HoldVal   = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0]   RepeatVal = CntW'(REPEAT_CYCLES);
  localparam logic [IdleW-1:0]  IdleVal   = IdleW'(IDLE_CYCLES);
  localparam logic [BlinkW-1:0] BlinkVal  = BlinkW'(BLINK_CYCLES);

  // Encoding doubles as the field_sel value.
  typedef enum logic [1:0] {
    StRun        = 2'b00,
    StSetHours   = 2'b01,
    StSetMinutes = 2'b10,
    StSetSeconds = 2'b11
  } state_e;

  state_e state_q, state_d, state_next;

  logic mode_prev_q, add_prev_q, sub_prev_q;
  logic mode_press, add_press, sub_press, add_or_sub;
  logic tick_q, tick_d, inc_q, inc_d, dec_q, dec_d;
  logic blank_q, blank_d, lockout_q, lockout_d, rep_q, rep_d;

  logic [CntW-1:0]   cnt_q, cnt_d, cnt_limit;
  logic [IdleW-1:0]  idle_q, idle_d, idle_inc;
  logic [BlinkW-1:0] blink_q, blink_d, blink_inc;

  assign mode_press = mode_button & ~mode_prev_q;
  assign add_press  = add_button & ~add_prev_q;
  assign sub_press  = sub_button & ~sub_prev_q;
  assign add_or_sub = add_button | sub_button;

  assign idle_inc  = idle_q + IdleW'(1);
  assign blink_inc = blink_q + BlinkW'(1);
  assign cnt_limit = rep_q ? RepeatVal : HoldVal;

  always_comb begin
    state_next = StRun;
    unique case (state_q)
      StRun:        state_next = StSetHours;
      StSetHours:   state_next = StSetMinutes;
      StSetMinutes: state_next = StSetSeconds;
      StSetSeconds: state_next = StRun;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = pulse_1hz & (state_q == StRun);
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    lockout_d = lockout_q;
    idle_d    = idle_q;
    blink_d   = blink_q;
    blank_d   = blank_q;

    if (state_q == StRun) begin
      cnt_d     = '0;
      rep_d     = 1'b0;
      idle_d    = '0;
      blink_d   = '0;
      blank_d   = 1'b0;
      lockout_d = lockout_q & add_or_sub;
      if (mode_press) begin
        state_d   = state_next;
        lockout_d = add_or_sub;
      end
    end else begin
      // Button handling: mode wins, then lockout, then chord, then press, then hold.
      if (mode_press) begin
        state_d   = state_next;
        cnt_d     = '0;
        rep_d     = 1'b0;
        lockout_d = add_or_sub;
      end else if (lockout_q) begin
        cnt_d     = '0;
        rep_d     = 1'b0;
        lockout_d = add_or_sub;
      end else if (add_button && sub_button) begin
        cnt_d     = '0;
        rep_d     = 1'b0;
        lockout_d = 1'b1;
      end else if (add_press || sub_press) begin
        inc_d = add_press;
        dec_d = sub_press;
        cnt_d = CntW'(1);
        rep_d = 1'b0;
      end else if (add_or_sub && (cnt_q != '0)) begin
        if (cnt_q == cnt_limit) begin
          inc_d = add_button;
          dec_d = sub_button;
          cnt_d = CntW'(1);
          rep_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else begin
        cnt_d = '0;
        rep_d = 1'b0;
      end

      if (mode_button || add_or_sub) begin
        idle_d = '0;
      end else if (idle_inc == IdleVal) begin
        state_d = StRun;
        idle_d  = '0;
      end else begin
        idle_d = idle_inc;
      end

      // Field stays lit while being adjusted so the new value is readable.
      if (state_d != state_q || add_or_sub) begin
        blink_d = '0;
        blank_d = 1'b0;
      end else if (blink_inc == BlinkVal) begin
        blink_d = '0;
        blank_d = ~blank_q;
      end else begin
        blink_d = blink_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StRun;
      mode_prev_q <= 1'b1;
      add_prev_q  <= 1'b1;
      sub_prev_q  <= 1'b1;
      tick_q      <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      blank_q     <= 1'b0;
      lockout_q   <= 1'b0;
      rep_q       <= 1'b0;
      cnt_q       <= '0;
      idle_q      <= '0;
      blink_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_button;
      add_prev_q  <= add_button;
      sub_prev_q  <= sub_button;
      tick_q      <= tick_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      blank_q     <= blank_d;
      lockout_q   <= lockout_d;
      rep_q       <= rep_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      blink_q     <= blink_d;
    end
  end

  assign tick_en   = tick_q;
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
  assign blank     = blank_q;
  assign field_sel = state_q;
  assign setting   = (state_q != StRun);

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with small timing parameters.
module tb_clock_set_controller;

  logic       clock;
  logic       reset;
  logic       pulse_1hz;
  logic       mode_button;
  logic       add_button;
  logic       sub_button;
  logic       tick_en;
  logic       inc_pulse;
  logic       dec_pulse;
  logic [1:0] field_sel;
  logic       blank;
  logic       setting;

  int n_cmp = 0;
  int n_err = 0;

  clock_set_controller #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .BLINK_CYCLES (3),
    .IDLE_CYCLES  (50)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pulse_1hz  (pulse_1hz),
    .mode_button(mode_button),
    .add_button (add_button),
    .sub_button (sub_button),
    .tick_en    (tick_en),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .field_sel  (field_sel),
    .blank      (blank),
    .setting    (setting)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic press_mode();
    mode_button = 1'b1;
    step();
    mode_button = 1'b0;
    step();
  endtask

  task automatic send_pulse(input string tag, input logic exp_tick);
    pulse_1hz = 1'b1;
    step();
    chk1(tag, tick_en, exp_tick);
    pulse_1hz = 1'b0;
    step();
    chk1({tag, "_after"}, tick_en, 1'b0);
    repeat (8) step();
  endtask

  initial begin
    reset       = 1'b0;
    pulse_1hz   = 1'b0;
    mode_button = 1'b0;
    add_button  = 1'b0;
    sub_button  = 1'b0;
    step();
    step();
    chk2("rst_field", field_sel, 2'b00);
    chk1("rst_setting", setting, 1'b0);
    chk1("rst_blank", blank, 1'b0);
    chk1("rst_tick", tick_en, 1'b0);
    chk1("rst_inc", inc_pulse, 1'b0);
    chk1("rst_dec", dec_pulse, 1'b0);
    reset = 1'b1;
    step();

    // Ticks in RUN, dropped in every set state, resume after wrap to RUN.
    send_pulse("run_tick0", 1'b1);
    send_pulse("run_tick1", 1'b1);
    press_mode();
    chk2("mode1_field", field_sel, 2'b01);
    chk1("mode1_setting", setting, 1'b1);
    send_pulse("hours_drop", 1'b0);
    press_mode();
    chk2("mode2_field", field_sel, 2'b10);
    send_pulse("minutes_drop", 1'b0);
    press_mode();
    chk2("mode3_field", field_sel, 2'b11);
    send_pulse("seconds_drop", 1'b0);
    press_mode();
    chk2("mode4_field", field_sel, 2'b00);
    chk1("mode4_setting", setting, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("no_catchup", tick_en, 1'b0);
    end
    send_pulse("run_resume", 1'b1);

    // Hold-to-repeat in SET_MINUTES.
    press_mode();
    press_mode();
    chk2("min_field", field_sel, 2'b10);
    add_button = 1'b1;
    step();
    chk1("hold_first_inc", inc_pulse, 1'b1);
    chk1("hold_first_dec", dec_pulse, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk1("hold_inc", inc_pulse, (i == 8) || (i == 12) || (i == 16) || (i == 20));
      chk1("hold_dec", dec_pulse, 1'b0);
      chk1("hold_blank", blank, 1'b0);
    end
    add_button = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk1("release_inc", inc_pulse, 1'b0);
    end

    // Sub held, add joins: chord lockout until both low.
    sub_button = 1'b1;
    step();
    chk1("sub_first_dec", dec_pulse, 1'b1);
    chk1("sub_first_inc", inc_pulse, 1'b0);
    step();
    chk1("sub_held1", dec_pulse, 1'b0);
    step();
    chk1("sub_held2", dec_pulse, 1'b0);
    add_button = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("chord_dec", dec_pulse, 1'b0);
      chk1("chord_inc", inc_pulse, 1'b0);
    end
    sub_button = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("chord_add_only", inc_pulse, 1'b0);
    end
    add_button = 1'b0;
    step();
    chk1("chord_clear", dec_pulse, 1'b0);
    sub_button = 1'b1;
    step();
    chk1("sub_repress", dec_pulse, 1'b1);
    step();
    chk1("sub_repress_single", dec_pulse, 1'b0);
    sub_button = 1'b0;
    step();

    // Mode and add in the same cycle from SET_HOURS.
    press_mode();
    press_mode();
    press_mode();
    chk2("hours_field", field_sel, 2'b01);
    mode_button = 1'b1;
    add_button  = 1'b1;
    step();
    chk2("mode_add_field", field_sel, 2'b10);
    chk1("mode_add_inc", inc_pulse, 1'b0);
    mode_button = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk1("mode_add_held", inc_pulse, 1'b0);
    end
    add_button = 1'b0;
    step();
    chk1("mode_add_release", inc_pulse, 1'b0);
    add_button = 1'b1;
    step();
    chk1("mode_add_repress", inc_pulse, 1'b1);
    add_button = 1'b0;
    step();
    chk1("mode_add_repress_end", inc_pulse, 1'b0);

    // Blink and idle timeout in SET_SECONDS.
    mode_button = 1'b1;
    step();
    chk2("sec_field", field_sel, 2'b11);
    chk1("sec_blank0", blank, 1'b0);
    mode_button = 1'b0;
    for (int i = 1; i <= 49; i++) begin
      logic exp_blank;
      step();
      exp_blank = ((i / 3) % 2) == 1;
      chk1("blink", blank, exp_blank);
    end
    chk1("idle49_setting", setting, 1'b1);
    step();
    chk2("idle_field", field_sel, 2'b00);
    chk1("idle_setting", setting, 1'b0);
    chk1("idle_blank", blank, 1'b0);

    // Reset mid-repeat, add held through reset release.
    press_mode();
    press_mode();
    add_button = 1'b1;
    step();
    chk1("pre_reset_inc", inc_pulse, 1'b1);
    repeat (9) step();
    reset = 1'b0;
    step();
    chk2("midrep_rst_field", field_sel, 2'b00);
    chk1("midrep_rst_setting", setting, 1'b0);
    chk1("midrep_rst_inc", inc_pulse, 1'b0);
    step();
    chk1("midrep_rst_inc2", inc_pulse, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("post_rst_inc", inc_pulse, 1'b0);
    end
    mode_button = 1'b1;
    step();
    chk2("post_rst_mode", field_sel, 2'b01);
    chk1("post_rst_mode_inc", inc_pulse, 1'b0);
    mode_button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("post_rst_held", inc_pulse, 1'b0);
    end
    add_button = 1'b0;
    step();
    chk1("post_rst_release", inc_pulse, 1'b0);
    add_button = 1'b1;
    step();
    chk1("post_rst_repress", inc_pulse, 1'b1);
    add_button = 1'b0;
    step();
    chk1("post_rst_repress_end", inc_pulse, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
